// File: rtl/i2c_byte_sequencer.sv
// I2C single-byte sequencer: loads an external N-bit shift register, clocks it out/in on SCL/SDA, reports ACK.
// Optional arbitration-loss abort on writes is compiled in with `define ARB_CHECK_EN.
module i2c_byte_sequencer #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_rw,
  input  logic [N-1:0] cmd_data,
  input  logic         cmd_ack_out,
  input  logic [N-1:0] fu_q,
  output logic [N-1:0] fu_d,
  output logic [2:0]   fu_s,
  output logic         fu_msbin,
  output logic         fu_lsbin,
  output logic         fu_enable,
  output logic         scl_o,
  output logic         sda_oe,
  input  logic         sda_i,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_data,
  output logic         rsp_ack,
  output logic         rsp_arb_lost,
  output logic         busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  div_q;
  logic [1:0]     qtr_q;
  logic [BW-1:0]  bit_q;
  logic           cmdRw_q;
  logic           cmdAckOut_q;
  logic           sample_q;
  logic           rspValid_q;
  logic [N-1:0]   rspData_q;
  logic           rspAck_q;
  logic           arbLost_q;

  logic accept;
  logic quarterEnd;
  logic sampleCycle;
  logic bitEnd;
  logic shiftNow;
  logic arbAbort;

  assign accept      = cmd_valid && (state_q == S_IDLE);
  assign quarterEnd  = (div_q == DIV_LAST);
  assign sampleCycle = (qtr_q == 2'd2) && (div_q == '0);
  assign bitEnd      = (qtr_q == 2'd3) && quarterEnd;
  assign shiftNow    = (state_q == S_BIT) && bitEnd;

`ifdef ARB_CHECK_EN
  // We released SDA to send a 1 but the line reads 0: another master owns the bus.
  assign arbAbort = (state_q == S_BIT) && !cmdRw_q && fu_q[N-1] && sampleCycle && !sda_i;
`else
  assign arbAbort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      cmdRw_q     <= 1'b0;
      cmdAckOut_q <= 1'b1;
      sample_q    <= 1'b0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      rspAck_q    <= 1'b1;
      arbLost_q   <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmdRw_q     <= cmd_rw;
            cmdAckOut_q <= cmd_ack_out;
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            state_q     <= S_BIT;
          end
        end
        S_BIT, S_ACK: begin
          if (sampleCycle) sample_q <= sda_i;
          if (arbAbort) begin
            state_q    <= S_DONE;
            rspValid_q <= 1'b1;
            rspData_q  <= fu_q;
            rspAck_q   <= 1'b1;
            arbLost_q  <= 1'b1;
          end else begin
            div_q <= quarterEnd ? '0 : div_q + DW'(1);
            if (quarterEnd) qtr_q <= qtr_q + 2'd1;
            if (bitEnd) begin
              if (state_q == S_BIT) begin
                if (bit_q == BIT_LAST) begin
                  bit_q   <= '0;
                  state_q <= S_ACK;
                end else begin
                  bit_q <= bit_q + BW'(1);
                end
              end else begin
                // The ACK bit was sampled in Q2 of this bit, so sample_q is already valid here.
                state_q    <= S_DONE;
                rspValid_q <= 1'b1;
                rspData_q  <= fu_q;
                rspAck_q   <= cmdRw_q ? cmdAckOut_q : sample_q;
                arbLost_q  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          div_q   <= '0;
          qtr_q   <= '0;
          bit_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  assign scl_o = (state_q == S_IDLE) ||
                 (((state_q == S_BIT) || (state_q == S_ACK)) && ((qtr_q == 2'd1) || (qtr_q == 2'd2)));

  assign sda_oe = ((state_q == S_BIT) && !cmdRw_q && !fu_q[N-1]) ||
                  ((state_q == S_ACK) && cmdRw_q && !cmdAckOut_q);

  assign fu_d      = accept ? cmd_data : '0;
  assign fu_s      = accept ? 3'd1 : (shiftNow ? 3'd3 : 3'd0);
  assign fu_enable = accept || shiftNow;
  assign fu_lsbin  = shiftNow && sample_q;
  assign fu_msbin  = 1'b0;

  assign rsp_valid    = rspValid_q;
  assign rsp_data     = rspData_q;
  assign rsp_ack      = rspAck_q;
  assign rsp_arb_lost = arbLost_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Directed bench for i2c_byte_sequencer with a behavioural shift register and an open-drain bus/slave model.
module tb_i2c_byte_sequencer;

  localparam int N       = 8;
  localparam int CD      = 2;
  localparam int BIT_CYC = 4 * CD;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_rw;
  logic [N-1:0] cmd_data;
  logic         cmd_ack_out;
  logic [N-1:0] fu_q;
  logic [N-1:0] fu_d;
  logic [2:0]   fu_s;
  logic         fu_msbin;
  logic         fu_lsbin;
  logic         fu_enable;
  logic         scl_o;
  logic         sda_oe;
  logic         sda_i;
  logic         rsp_valid;
  logic [N-1:0] rsp_data;
  logic         rsp_ack;
  logic         rsp_arb_lost;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  i2c_byte_sequencer #(.N(N), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_data(cmd_data), .cmd_ack_out(cmd_ack_out),
    .fu_q(fu_q), .fu_d(fu_d), .fu_s(fu_s), .fu_msbin(fu_msbin),
    .fu_lsbin(fu_lsbin), .fu_enable(fu_enable),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .rsp_arb_lost(rsp_arb_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  // Universal shift register seen by the sequencer: hold, load, shift left with LSBIn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fu_q <= '0;
    else if (fu_enable) begin
      case (fu_s)
        3'd1:    fu_q <= fu_d;
        3'd3:    fu_q <= {fu_q[N-2:0], fu_lsbin};
        default: fu_q <= fu_q;
      endcase
    end
  end

  // Cycle bookkeeping relative to the last accepted command.
  int phaseCnt      = 100000;
  int cycleNo       = 0;
  int acceptCount   = 0;
  int lastAccept    = 0;
  int acceptSpacing = 0;
  always @(posedge clk) begin
    cycleNo <= cycleNo + 1;
    if (cmd_valid && cmd_ready) begin
      phaseCnt      <= 0;
      acceptCount   <= acceptCount + 1;
      acceptSpacing <= cycleNo - lastAccept;
      lastAccept    <= cycleNo;
    end else begin
      phaseCnt <= phaseCnt + 1;
    end
  end

  // Slave drives its byte MSB first, then its ACK level; wired-AND with the master.
  logic [7:0] slaveByte = 8'hFF;
  logic       slaveAck  = 1'b1;
  logic       slaveDrive;
  int         bitIdx;
  always_comb begin
    bitIdx     = phaseCnt / BIT_CYC;
    slaveDrive = 1'b1;
    if (bitIdx < 8) slaveDrive = slaveByte[3'(7 - bitIdx)];
    else if (bitIdx == 8) slaveDrive = slaveAck;
  end
  assign sda_i = ~sda_oe & slaveDrive;

  logic       sclPrev   = 1'b1;
  logic [8:0] busBits   = '0;
  int         sclRises  = 0;
  always @(negedge clk) begin
    if (scl_o && !sclPrev && busy) begin
      busBits  = {busBits[7:0], sda_i};
      sclRises = sclRises + 1;
    end
    sclPrev = scl_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [7:0] data, input logic ackOut,
                               input logic [7:0] sByte, input logic sAck,
                               input int expLat, input logic [7:0] expData, input logic expAck,
                               input logic expArb, input int expOeBit, input int expOeAck,
                               input logic checkBus, input logic [8:0] expBus);
    int  k;
    int  oeBit;
    int  oeAck;
    bit  done;
    @(negedge clk);
    slaveByte   = sByte;
    slaveAck    = sAck;
    cmd_valid   = 1'b1;
    cmd_rw      = rw;
    cmd_data    = data;
    cmd_ack_out = ackOut;
    sclRises    = 0;
    #1;
    checkOutput("acceptFuS", 32'(fu_s), 32'd1);
    checkOutput("acceptFuEn", 32'(fu_enable), 32'd1);
    checkOutput("acceptFuD", 32'(fu_d), 32'(data));
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1; oeBit = 0; oeAck = 0; done = 0;
    while (k <= expLat + 20 && !done) begin
      if (k == 2) checkOutput("readyWhileBusy", 32'(cmd_ready), 32'd0);
      if (rsp_valid) done = 1;
      else begin
        if (k <= 32 * CD && sda_oe) oeBit++;
        else if (k > 32 * CD && sda_oe) oeAck++;
        @(negedge clk);
        k++;
      end
    end
    checkOutput("latency", done ? 32'(k) : 32'hFFFF_FFFF, 32'(expLat));
    checkOutput("rspData", 32'(rsp_data), 32'(expData));
    checkOutput("rspAck", 32'(rsp_ack), 32'(expAck));
    checkOutput("rspArbLost", 32'(rsp_arb_lost), 32'(expArb));
    checkOutput("doneScl", 32'(scl_o), 32'd0);
    checkOutput("oeDuringBits", 32'(oeBit), 32'(expOeBit));
    checkOutput("oeDuringAck", 32'(oeAck), 32'(expOeAck));
    if (checkBus) begin
      checkOutput("busBits", 32'(busBits), 32'(expBus));
      checkOutput("sclPulses", 32'(sclRises), 32'd9);
    end
    @(negedge clk);
    checkOutput("postValid", 32'(rsp_valid), 32'd0);
    checkOutput("postReady", 32'(cmd_ready), 32'd1);
    checkOutput("postScl", 32'(scl_o), 32'd1);
    checkOutput("postDataHeld", 32'(rsp_data), 32'(expData));
  endtask

  initial begin
    int startCount;
    int n;
    int strobes;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_data = '0; cmd_ack_out = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    #2 rst = 1'b1;
    #1;
    checkOutput("rstScl", 32'(scl_o), 32'd1);
    checkOutput("rstSdaOe", 32'(sda_oe), 32'd0);
    checkOutput("rstReady", 32'(cmd_ready), 32'd1);
    checkOutput("rstValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAck", 32'(rsp_ack), 32'd1);
    checkOutput("rstData", 32'(rsp_data), 32'd0);
    checkOutput("rstArb", 32'(rsp_arb_lost), 32'd0);
    checkOutput("rstFuS", 32'(fu_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write 0xA5, slave ACKs: bus shows A5 then 0; four zero bits x 8 cycles driven low.
    applyStimulus(1'b0, 8'hA5, 1'b1, 8'hFF, 1'b0, 73, 8'hA5, 1'b0, 1'b0, 32, 0, 1'b1, 9'h14A);
    // Write 0x3C, slave NACKs.
    applyStimulus(1'b0, 8'h3C, 1'b1, 8'hFF, 1'b1, 73, 8'h3C, 1'b1, 1'b0, 32, 0, 1'b1, 9'h079);
    // Read 0x96, master ACKs for the whole ACK bit.
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h96, 1'b1, 73, 8'h96, 1'b0, 1'b0, 0, 8, 1'b1, 9'h12C);

    // Reset during bit 4 of a write of 0xA5 (bit 4 is 0, so SDA is being pulled low).
    @(negedge clk);
    slaveByte = 8'hFF; slaveAck = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_data = 8'hA5; cmd_ack_out = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (35) @(negedge clk);
    checkOutput("midByteOe", 32'(sda_oe), 32'd1);
    checkOutput("midByteBusy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstSdaOe", 32'(sda_oe), 32'd0);
    checkOutput("midRstScl", 32'(scl_o), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid) strobes++;
    end
    checkOutput("noRspAfterRst", 32'(strobes), 32'd0);
    applyStimulus(1'b0, 8'h5A, 1'b1, 8'hFF, 1'b0, 73, 8'h5A, 1'b0, 1'b0, 32, 0, 1'b1, 9'h0B4);

    // cmd_valid held high: one acceptance per byte, starts spaced by the full transaction plus DONE.
    @(negedge clk);
    startCount = acceptCount;
    slaveByte = 8'hFF; slaveAck = 1'b0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_data = 8'h81; cmd_ack_out = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("oneAcceptWhileBusy", 32'(acceptCount - startCount), 32'd1);
    n = 0;
    while ((acceptCount - startCount) < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("secondAccept", 32'(acceptCount - startCount), 32'd2);
    checkOutput("startSpacing", 32'(acceptSpacing), 32'd74);
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleAfterHold", 32'(busy), 32'd0);
    checkOutput("holdRspData", 32'(rsp_data), 32'h81);

`ifdef ARB_CHECK_EN
    // Write 0xFF while another master pulls bit 7 low: abort after the bit-7 sample.
    applyStimulus(1'b0, 8'hFF, 1'b1, 8'hFE, 1'b1, 62, 8'hFF, 1'b1, 1'b1, 0, 0, 1'b0, 9'h000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
